// File: rtl/ram_port_arb.sv
// Round-robin arbiter that shares one RAM port among N requesters. It has a bounded
// per-requester burst lock, a registered command stage and fixed-latency read return.
module ram_port_arb #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int N          = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            req,
    input  logic [N-1:0]            we,
    input  logic [N*ADDR_WIDTH-1:0] addr,
    input  logic [N*DATA_WIDTH-1:0] wdata,
    input  logic [N-1:0]            lock,
    output logic [N-1:0]            gnt,
    output logic [N-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [ADDR_WIDTH-1:0]   ram_a,
    output logic [DATA_WIDTH-1:0]   ram_d,
    output logic                    ram_w,
    input  logic [DATA_WIDTH-1:0]   ram_q
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = IW + 1;

    logic [IW-1:0]         ptr;
    logic [IW-1:0]         owner;
    logic [7:0]            burst_cnt;

    logic                  gnt_any;
    logic [IW-1:0]         gnt_idx;
    logic [CW-1:0]         cand;

    logic [7:0]            run_len;
    logic [IW-1:0]         ptr_next;
    logic [7:0]            cnt_next;

    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic                  rd_v1;
    logic                  rd_v2;
    logic [IW-1:0]         rd_tag1;
    logic [IW-1:0]         rd_tag2;

    // Scan from ptr upward with wrap-around; the first requester found wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + CW'(k);
            if (cand >= CW'(N)) begin
                cand = cand - CW'(N);
            end
            if (rst && !gnt_any && req[cand[IW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        gnt          = '0;
        gnt[gnt_idx] = gnt_any;
    end

    always_comb begin
        sel_we    = we[gnt_idx];
        sel_addr  = addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    end

    // A grant to a new owner counts its burst from zero, not from the old owner's count.
    always_comb begin
        run_len  = (gnt_idx == owner) ? burst_cnt : '0;
        ptr_next = ptr;
        cnt_next = burst_cnt;
        if (gnt_any) begin
            if (lock[gnt_idx] && (({1'b0, run_len} + 9'd1) < 9'(MAX_BURST))) begin
                ptr_next = gnt_idx;
                cnt_next = run_len + 8'd1;
            end else begin
                ptr_next = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
                cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            ram_a     <= '0;
            ram_d     <= '0;
            ram_w     <= 1'b0;
            rd_v1     <= 1'b0;
            rd_v2     <= 1'b0;
            rd_tag1   <= '0;
            rd_tag2   <= '0;
        end else begin
            ptr       <= ptr_next;
            burst_cnt <= cnt_next;
            ram_w     <= gnt_any && sel_we;
            rd_v1     <= gnt_any && !sel_we;
            rd_v2     <= rd_v1;
            rd_tag2   <= rd_tag1;
            if (gnt_any) begin
                owner   <= gnt_idx;
                rd_tag1 <= gnt_idx;
                ram_a   <= sel_addr;
                ram_d   <= sel_wdata;
            end
        end
    end

    // The RAM output register supplies the second cycle of read latency, so rdata is a pass-through.
    always_comb begin
        rvalid          = '0;
        rvalid[rd_tag2] = rd_v2;
    end

    assign rdata = ram_q;

endmodule
